// File: rtl/gamepad_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gamepad_scan_pkg                                                           |
// | Shared types and helpers for the gamepad poll scheduler.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gamepad_scan_pkg;

    localparam int c_RESULT_W  = 16;
    localparam int c_MAX_SLOTS = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_NEXT = 3'd1,
        ST_ARM  = 3'd2,
        ST_WAIT = 3'd3,
        ST_CAPT = 3'd4
    } scan_state_t;

    // Lowest index >= start with its mask bit set, or -1 when none remain.
    function automatic int next_masked_slot(input logic [c_MAX_SLOTS-1:0] mask,
                                            input int start,
                                            input int n_slots);
        int found;
        found = -1;
        for (int i = c_MAX_SLOTS - 1; i >= 0; i--) begin
            if (i >= start && i < n_slots && mask[i]) begin
                found = i;
            end
        end
        return found;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gamepad_scan_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gamepad_scan_timer                                                         |
// | Periodic scan timer plus coalescing pending-request flag.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gamepad_scan_timer #(
    parameter int PERIOD = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic scan_en,
    input  logic scan_trig,
    input  logic take,
    output logic pending
);

    localparam int c_CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [c_CNT_W-1:0] r_count;
    logic               r_pending;
    logic               w_wrap;

    assign w_wrap = scan_en && (r_count == c_CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!scan_en || w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    // Any number of requests collapse into a single flag; a new request beats a take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (w_wrap || scan_trig) begin
            r_pending <= 1'b1;
        end else if (take) begin
            r_pending <= 1'b0;
        end
    end

    assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/gamepad_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gamepad_scan_ctrl                                                          |
// | Poll scheduler for gamepad_od with per-slot result file and change flags.  |
// | Optional: GAMEPAD_SCAN_DEBOUNCE_EN (commit only on two identical polls).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gamepad_scan_ctrl
    import gamepad_scan_pkg::*;
#(
    parameter int SEL_WIDTH = 1,
    parameter int PERIOD    = 20000,
    parameter int TIMEOUT   = 4096,
    localparam int N_SLOTS  = 2 ** SEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_en,
    input  logic                  scan_trig,
    input  logic [N_SLOTS-1:0]    slot_mask,
    input  logic                  mux_cfg,
    output logic                  ctrl_go,
    output logic [SEL_WIDTH-1:0]  ctrl_sel,
    output logic                  ctrl_mux,
    input  logic                  ctrl_rdy,
    input  logic [c_RESULT_W-1:0] gp_value,
    input  logic [SEL_WIDTH-1:0]  rd_addr,
    output logic [c_RESULT_W-1:0] rd_data,
    output logic [N_SLOTS-1:0]    slot_valid,
    output logic [N_SLOTS-1:0]    slot_chg,
    input  logic [N_SLOTS-1:0]    chg_clr,
    output logic                  busy,
    output logic                  irq
);

    localparam int c_TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    scan_state_t          r_state;
    logic [SEL_WIDTH:0]   r_slot;
    logic                 r_ctrl_go;
    logic [SEL_WIDTH-1:0] r_ctrl_sel;
    logic                 r_ctrl_mux;
    logic                 r_busy;
    logic                 r_rdy_prev;
    logic [c_TO_W-1:0]    r_to_cnt;

    logic                  w_pending;
    logic                  w_take;
    logic                  w_done;
    logic                  w_abort;
    int                    w_next_int;
    logic [SEL_WIDTH:0]    w_next_slot;
    logic [SEL_WIDTH-1:0]  w_idx;
    logic [c_RESULT_W-1:0] w_file [N_SLOTS];

    gamepad_scan_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .scan_en   (scan_en),
        .scan_trig (scan_trig),
        .take      (w_take),
        .pending   (w_pending)
    );

    assign w_take      = (r_state == ST_IDLE) && w_pending;
    assign w_next_int  = next_masked_slot(c_MAX_SLOTS'(slot_mask), int'(r_slot), N_SLOTS);
    assign w_next_slot = (SEL_WIDTH + 1)'(w_next_int);
    assign w_idx       = r_slot[SEL_WIDTH-1:0];

    // Completion is a rising rdy edge after go; it commits in the same cycle so
    // the result reaches rd_data one cycle after the engine raises rdy.
    assign w_done  = (r_state == ST_WAIT) && ctrl_rdy && !r_rdy_prev;
    assign w_abort = (r_state == ST_WAIT) && !w_done && (r_to_cnt == c_TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_slot     <= '0;
            r_ctrl_go  <= 1'b0;
            r_ctrl_sel <= '0;
            r_ctrl_mux <= 1'b0;
            r_busy     <= 1'b0;
            r_rdy_prev <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            r_ctrl_go <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pending) begin
                        r_slot  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (w_next_int < 0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_slot     <= w_next_slot;
                        r_ctrl_sel <= w_next_slot[SEL_WIDTH-1:0];
                        r_ctrl_mux <= mux_cfg;
                        r_state    <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (ctrl_rdy) begin
                        r_ctrl_go  <= 1'b1;
                        r_to_cnt   <= '0;
                        r_rdy_prev <= 1'b1;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_rdy_prev <= ctrl_rdy;
                    r_to_cnt   <= r_to_cnt + c_TO_W'(1);
                    if (w_done) begin
                        r_state <= ST_CAPT;
                    end else if (w_abort) begin
                        r_slot  <= r_slot + (SEL_WIDTH + 1)'(1);
                        r_state <= ST_NEXT;
                    end
                end
                ST_CAPT: begin
                    // Extra index bit lets the last slot step past the end instead of wrapping to 0.
                    r_slot  <= r_slot + (SEL_WIDTH + 1)'(1);
                    r_state <= ST_NEXT;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
        logic                  w_hit;
        logic                  w_commit;
        logic [c_RESULT_W-1:0] r_data;
        logic                  r_vld;
        logic                  r_chg;

        assign w_hit = (w_idx == SEL_WIDTH'(gi));

`ifdef GAMEPAD_SCAN_DEBOUNCE_EN
        logic [c_RESULT_W-1:0] r_cand;
        logic                  r_cand_vld;

        assign w_commit = w_done && w_hit && r_cand_vld && (r_cand == gp_value);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cand     <= '0;
                r_cand_vld <= 1'b0;
            end else if (w_done && w_hit) begin
                r_cand     <= gp_value;
                r_cand_vld <= 1'b1;
            end else if (w_abort && w_hit) begin
                r_cand_vld <= 1'b0;
            end
        end
`else
        assign w_commit = w_done && w_hit;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data <= '0;
                r_vld  <= 1'b0;
                r_chg  <= 1'b0;
            end else begin
                if (w_commit) begin
                    r_data <= gp_value;
                    r_vld  <= 1'b1;
                end else if (w_abort && w_hit) begin
                    r_vld <= 1'b0;
                end
                r_chg <= (w_commit && (!r_vld || (r_data != gp_value))) || (r_chg && !chg_clr[gi]);
            end
        end

        assign w_file[gi]     = r_data;
        assign slot_valid[gi] = r_vld;
        assign slot_chg[gi]   = r_chg;
    end

    assign rd_data  = w_file[rd_addr];
    assign irq      = |slot_chg;
    assign ctrl_go  = r_ctrl_go;
    assign ctrl_sel = r_ctrl_sel;
    assign ctrl_mux = r_ctrl_mux;
    assign busy     = r_busy;

endmodule
`default_nettype wire
